bcd_counter_2d: RTL

Two-digit synchronous BCD up/down counter (00–99) with parallel load, configurable terminal value and wrap/saturate mode. It is the source stage for `bcd_bin`: its `bcd[7:0]` output (tens nibble [7:4], ones nibble [3:0]) drives `bcd_bin.bcd` directly. The `bcd_valid` strobe marks each cycle in which a new value is presented. The counter rejects loads that are not valid BCD or that exceed the terminal value, so the downstream converter never sees a nibble above 9.

---
 rtl/bcd_counter_2d_if.sv | 13 +
 rtl/bcd_counter_2d.sv | 39 +++
 2 files changed

// File: rtl/bcd_counter_2d_if.sv
// bcd_counter_2d_if: control and count bundle between a BCD counter and its user
interface bcd_counter_2d_if;
  logic en;
  logic up_dn;
  logic load;
  logic [7:0] load_bcd;
  logic [7:0] bcd;
  logic bcd_valid;
  logic tc;
  logic err;
  modport master(output en, up_dn, load, load_bcd, input bcd, bcd_valid, tc, err);
  modport slave(input en, up_dn, load, load_bcd, output bcd, bcd_valid, tc, err);
endinterface

// File: rtl/bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD up/down counter with checked load and wrap/saturate ends
module bcd_counter_2d #(
  parameter int MAX_COUNT = 99,
  parameter bit WRAP = 1'b1
) (
  input logic clk,
  input logic rst_n,
  bcd_counter_2d_if.slave bus
);
  localparam logic [7:0] MAX_BCD = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};
  logic [7:0] cnt, nxt, up_nxt, dn_nxt;
  logic valid, err, load_ok, at_max, at_zero;
  logic [3:0] t, o;
  assign t = cnt[7:4];
  assign o = cnt[3:0];
  assign at_max = cnt == MAX_BCD;
  assign at_zero = cnt == 8'h00;
  // with both nibbles legal, a plain byte compare orders BCD values correctly
  assign load_ok = bus.load_bcd[7:4] <= 4'd9 && bus.load_bcd[3:0] <= 4'd9 && bus.load_bcd <= MAX_BCD;
  always_comb begin
    up_nxt = at_max ? (WRAP ? 8'h00 : cnt) : (o == 4'd9 ? {t + 4'd1, 4'd0} : {t, o + 4'd1});
    dn_nxt = at_zero ? (WRAP ? MAX_BCD : cnt) : (o == 4'd0 ? {t - 4'd1, 4'd9} : {t, o - 4'd1});
    nxt = bus.load ? (load_ok ? bus.load_bcd : cnt) : bus.en ? (bus.up_dn ? up_nxt : dn_nxt) : cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 8'h00;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= nxt;
      valid <= nxt != cnt;
      err <= bus.load ? !load_ok : err;
    end
  assign bus.bcd = cnt;
  assign bus.bcd_valid = valid;
  assign bus.err = err;
  assign bus.tc = bus.up_dn ? at_max : at_zero;
endmodule
